// File: rtl/csc_line_arbiter_pkg.sv
// Shared defaults and types for the line-granting colour-space-converter arbiter.
// Pixel packing: ycc = {Y, Cb, Cr}, rgb = {R, G, B}, each DSIZE bits, first component in the MSBs.
package csc_pkg;

    localparam int DSIZE_DEF    = 16;
    localparam int CSC_LAT_DEF  = 4;
    localparam int MAX_LINE_DEF = 4096;

    // Tag carried alongside each pixel through the converter: {de, id, last}
    localparam int TAG_W  = 3;
    localparam int TAG_DE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

endpackage

// File: rtl/csc_line_arbiter_tag_pipe.sv
// Fixed-depth shift register that carries {de, id, last} in lock-step with the converter pipeline.
module csc_tag_pipe
    import csc_pkg::*;
#(
    parameter int DEPTH = CSC_LAT_DEF,
    parameter int WIDTH = TAG_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_valid
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per cycle; reset drops every in-flight tag
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

    // OR of the de bit across all stages
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_r[i][TAG_DE];
        end
    end

endmodule

// File: rtl/csc_line_arbiter.sv
// Shares one fixed-latency YCbCr->RGB converter between two streams, granting whole lines
// round-robin and re-tagging the converter output with source id and end-of-line.
module csc_line_arbiter
    import csc_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int CSC_LAT  = CSC_LAT_DEF,
    parameter int MAX_LINE = MAX_LINE_DEF
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               s0_valid,
    input  logic               s0_last,
    input  logic [3*DSIZE-1:0] s0_ycc,
    output logic               s0_ready,
    input  logic               s1_valid,
    input  logic               s1_last,
    input  logic [3*DSIZE-1:0] s1_ycc,
    output logic               s1_ready,
    output logic               csc_de,
    output logic [3*DSIZE-1:0] csc_ycc,
    input  logic [3*DSIZE-1:0] csc_rgb,
    output logic               m_valid,
    output logic               m_id,
    output logic               m_last,
    output logic [3*DSIZE-1:0] m_rgb,
    output logic               line_abort,
    output logic               busy
);

    localparam int LW = $clog2(MAX_LINE);
    localparam logic [LW-1:0] CNT_LAST = LW'(MAX_LINE - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic               rr_r;
    logic [LW-1:0]      pix_cnt_r;
    logic               xfer_s;
    logic               gnt_id_s;
    logic               gnt_last_s;
    logic [3*DSIZE-1:0] gnt_ycc_s;
    logic               at_max_s;
    logic               force_rel_s;
    logic               tag_id_r;
    logic               tag_last_r;
    logic [TAG_W-1:0]   tag_out_s;
    logic               pipe_busy_s;

    assign s0_ready    = (state_r == G0);
    assign s1_ready    = (state_r == G1);
    assign at_max_s    = (pix_cnt_r == CNT_LAST);
    assign force_rel_s = xfer_s & at_max_s & ~gnt_last_s;

    // Next-state and granted-stream mux
    always_comb begin
        state_next_s = state_r;
        xfer_s       = 1'b0;
        gnt_id_s     = 1'b0;
        gnt_last_s   = 1'b0;
        gnt_ycc_s    = s0_ycc;
        case (state_r)
            IDLE: begin
                if (s0_valid && (!s1_valid || !rr_r)) begin
                    state_next_s = G0;
                end else if (s1_valid && (!s0_valid || rr_r)) begin
                    state_next_s = G1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            G0: begin
                xfer_s     = s0_valid;
                gnt_last_s = s0_last;
                if (xfer_s && (s0_last || at_max_s)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = G0;
                end
            end
            G1: begin
                xfer_s     = s1_valid;
                gnt_id_s   = 1'b1;
                gnt_last_s = s1_last;
                gnt_ycc_s  = s1_ycc;
                if (xfer_s && (s1_last || at_max_s)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = G1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line pixel counter and round-robin pointer (favour the other stream after each line)
    always_ff @(posedge clock) begin
        if (rst) begin
            pix_cnt_r <= {LW{1'b0}};
            rr_r      <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                pix_cnt_r <= {LW{1'b0}};
            end else if (xfer_s) begin
                pix_cnt_r <= pix_cnt_r + LW'(1);
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
            if ((state_r != IDLE) && (state_next_s == IDLE)) begin
                rr_r <= (state_r == G0);
            end else begin
                rr_r <= rr_r;
            end
        end
    end

    // Converter input register plus the tag that travels with it
    always_ff @(posedge clock) begin
        if (rst) begin
            csc_de     <= 1'b0;
            csc_ycc    <= {3*DSIZE{1'b0}};
            tag_id_r   <= 1'b0;
            tag_last_r <= 1'b0;
            line_abort <= 1'b0;
        end else begin
            csc_de     <= xfer_s;
            csc_ycc    <= xfer_s ? gnt_ycc_s : csc_ycc;
            tag_id_r   <= xfer_s & gnt_id_s;
            tag_last_r <= xfer_s & (gnt_last_s | at_max_s);
            line_abort <= force_rel_s;
        end
    end

    csc_tag_pipe #(
        .DEPTH (CSC_LAT),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clock     (clock),
        .rst       (rst),
        .din       ({csc_de, tag_id_r, tag_last_r}),
        .dout      (tag_out_s),
        .any_valid (pipe_busy_s)
    );

    // Converter has no reset, so its output is masked until a valid tag lines up with it
    assign {m_valid, m_id, m_last} = tag_out_s;
    assign m_rgb = m_valid ? csc_rgb : {3*DSIZE{1'b0}};
    assign busy  = (state_r != IDLE) | csc_de | pipe_busy_s;

endmodule

// File: tb/tb_csc_line_arbiter.sv
// Directed bench for csc_line_arbiter with a behavioural fixed-latency converter model.
module tb_csc_line_arbiter;
    import csc_pkg::*;

    localparam int DSIZE    = 16;
    localparam int CSC_LAT  = 4;
    localparam int MAX_LINE = 16;
    localparam int W        = 3*DSIZE;

    logic         clock = 1'b0;
    logic         rst;
    logic         s0_valid, s0_last, s0_ready;
    logic         s1_valid, s1_last, s1_ready;
    logic [W-1:0] s0_ycc, s1_ycc;
    logic         csc_de;
    logic [W-1:0] csc_ycc, csc_rgb;
    logic         m_valid, m_id, m_last;
    logic [W-1:0] m_rgb;
    logic         line_abort, busy;

    always #5 clock = ~clock;

    csc_line_arbiter #(.DSIZE(DSIZE), .CSC_LAT(CSC_LAT), .MAX_LINE(MAX_LINE)) dut (
        .clock(clock), .rst(rst),
        .s0_valid(s0_valid), .s0_last(s0_last), .s0_ycc(s0_ycc), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_last(s1_last), .s1_ycc(s1_ycc), .s1_ready(s1_ready),
        .csc_de(csc_de), .csc_ycc(csc_ycc), .csc_rgb(csc_rgb),
        .m_valid(m_valid), .m_id(m_id), .m_last(m_last), .m_rgb(m_rgb),
        .line_abort(line_abort), .busy(busy)
    );

    // Simple reference conversion: R = Y + (Cr-0x8000), G = Y, B = Y + (Cb-0x8000)
    function automatic logic [W-1:0] conv_fn(input logic [W-1:0] ycc);
        logic [15:0] y, cb, cr;
        y  = ycc[47:32];
        cb = ycc[31:16];
        cr = ycc[15:0];
        return {y + cr - 16'h8000, y, y + cb - 16'h8000};
    endfunction

    function automatic logic [W-1:0] mk(input logic [15:0] base, input int i);
        return {base + 16'(i), 16'h8000 + 16'(i), 16'h7f00 - 16'(i)};
    endfunction

    // Converter model: free-running, unreset pipeline of CSC_LAT stages
    logic [W-1:0] conv [CSC_LAT];
    always @(posedge clock) begin
        conv[0] <= conv_fn(csc_ycc);
        for (int i = 1; i < CSC_LAT; i++) conv[i] <= conv[i-1];
    end
    assign csc_rgb = conv[CSC_LAT-1];

    typedef struct { logic [W-1:0] ycc; logic last; int gap; } pix_t;
    typedef struct { int cyc; logic id; logic [W-1:0] ycc; logic last; } xrec_t;
    typedef struct { int cyc; logic id; logic last; logic [W-1:0] rgb; } orec_t;

    pix_t  q0[$], q1[$];
    xrec_t xl[$];
    orec_t ol[$];
    int    abort_cyc[$];
    int    ex_cyc[$];
    logic  ex_id[$], ex_last[$];
    logic [W-1:0] ex_ycc[$];
    int    cyc, leak, tests, fails;
    logic  acc0, acc1;

    // Monitor: samples on the falling edge
    initial begin
        cyc = 0; leak = 0; acc0 = 1'b0; acc1 = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            acc0 = (s0_valid === 1'b1) && (s0_ready === 1'b1);
            acc1 = (s1_valid === 1'b1) && (s1_ready === 1'b1);
            if (acc0) xl.push_back('{cyc, 1'b0, s0_ycc, s0_last});
            if (acc1) xl.push_back('{cyc, 1'b1, s1_ycc, s1_last});
            if (m_valid === 1'b1) ol.push_back('{cyc, m_id, m_last, m_rgb});
            if (m_valid === 1'b0 && m_rgb !== {W{1'b0}}) leak++;
            if (line_abort === 1'b1) abort_cyc.push_back(cyc);
        end
    end

    // Stream sources: present queue heads just after the rising edge
    initial begin
        s0_valid = 1'b0; s0_last = 1'b0; s0_ycc = {W{1'b0}};
        s1_valid = 1'b0; s1_last = 1'b0; s1_ycc = {W{1'b0}};
        forever begin
            @(posedge clock);
            #1;
            if (rst === 1'b1) begin
                q0.delete();
                q1.delete();
            end else begin
                if (acc0 && q0.size() > 0) void'(q0.pop_front());
                if (acc1 && q1.size() > 0) void'(q1.pop_front());
            end
            if (q0.size() > 0 && q0[0].gap == 0) begin
                s0_valid = 1'b1; s0_ycc = q0[0].ycc; s0_last = q0[0].last;
            end else begin
                s0_valid = 1'b0; s0_last = 1'b0;
                if (q0.size() > 0) q0[0].gap = q0[0].gap - 1;
            end
            if (q1.size() > 0 && q1[0].gap == 0) begin
                s1_valid = 1'b1; s1_ycc = q1[0].ycc; s1_last = q1[0].last;
            end else begin
                s1_valid = 1'b0; s1_last = 1'b0;
                if (q1.size() > 0) q1[0].gap = q1[0].gap - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic clear_logs();
        xl.delete(); ol.delete(); abort_cyc.delete();
        ex_cyc.delete(); ex_id.delete(); ex_last.delete(); ex_ycc.delete();
    endtask

    task automatic push(input int s, input logic [W-1:0] ycc, input logic last, input int gap);
        if (s == 0) q0.push_back('{ycc, last, gap});
        else        q1.push_back('{ycc, last, gap});
    endtask

    task automatic push_line(input int s, input int n, input logic [15:0] base, input logic last_end);
        for (int i = 0; i < n; i++) push(s, mk(base, i), last_end && (i == n-1), 0);
    endtask

    task automatic add_exp(input int c, input logic id, input logic [W-1:0] ycc, input logic last);
        ex_cyc.push_back(c); ex_id.push_back(id); ex_ycc.push_back(ycc); ex_last.push_back(last);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle_timeout"}, 64'(n < budget), 64'd1);
    endtask

    // Compare transfer and output logs against the expected per-pixel table
    task automatic check_logs(input string tag);
        chk({tag, "_xfer_count"}, 64'(xl.size()), 64'(ex_cyc.size()));
        chk({tag, "_out_count"},  64'(ol.size()), 64'(ex_cyc.size()));
        for (int i = 0; i < ex_cyc.size(); i++) begin
            if (i < xl.size()) begin
                chk($sformatf("%s_xcyc%0d", tag, i), 64'(xl[i].cyc), 64'(ex_cyc[i]));
                chk($sformatf("%s_xid%0d", tag, i),  64'(xl[i].id),  64'(ex_id[i]));
                chk($sformatf("%s_xycc%0d", tag, i), 64'(xl[i].ycc), 64'(ex_ycc[i]));
            end
            if (i < ol.size()) begin
                chk($sformatf("%s_ocyc%0d", tag, i),  64'(ol[i].cyc),  64'(ex_cyc[i] + 1 + CSC_LAT));
                chk($sformatf("%s_oid%0d", tag, i),   64'(ol[i].id),   64'(ex_id[i]));
                chk($sformatf("%s_olast%0d", tag, i), 64'(ol[i].last), 64'(ex_last[i]));
                chk($sformatf("%s_orgb%0d", tag, i),  64'(ol[i].rgb),  64'(conv_fn(ex_ycc[i])));
            end
        end
    endtask

    initial begin
        int t0, n;
        tests = 0; fails = 0;
        rst = 1'b1;
        tick(3);
        chk("rst_s0_ready", 64'(s0_ready), 64'd0);
        chk("rst_s1_ready", 64'(s1_ready), 64'd0);
        chk("rst_csc_de", 64'(csc_de), 64'd0);
        chk("rst_csc_ycc", 64'(csc_ycc), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_rgb", 64'(m_rgb), 64'd0);
        chk("rst_line_abort", 64'(line_abort), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(1);

        // 1: single 8-pixel line on stream 0
        clear_logs();
        t0 = cyc;
        push_line(0, 8, 16'h0100, 1'b1);
        for (int i = 0; i < 8; i++) add_exp(t0 + 2 + i, 1'b0, mk(16'h0100, i), i == 7);
        wait_idle("t1", 100);
        check_logs("t1");

        // 2: both streams busy, 4-pixel lines alternate with one bubble
        do_reset();
        clear_logs();
        t0 = cyc;
        push_line(0, 4, 16'h0200, 1'b1); push_line(0, 4, 16'h0210, 1'b1);
        push_line(1, 4, 16'h0300, 1'b1); push_line(1, 4, 16'h0310, 1'b1);
        for (int i = 0; i < 16; i++)
            add_exp(t0 + 2 + i + i/4, 1'(((i/4) % 2)),
                    mk(((i/4) % 2 == 1 ? 16'h0300 : 16'h0200) + 16'((i/8) * 16), i % 4), (i % 4) == 3);
        wait_idle("t2", 200);
        check_logs("t2");

        // 3: forced release after MAX_LINE pixels without last
        do_reset();
        clear_logs();
        t0 = cyc;
        push_line(1, 20, 16'h0400, 1'b0);
        tick(3);
        push_line(0, 2, 16'h0500, 1'b1);
        for (int i = 0; i < 16; i++) add_exp(t0 + 2 + i, 1'b1, mk(16'h0400, i), i == 15);
        for (int i = 0; i < 2; i++)  add_exp(t0 + 19 + i, 1'b0, mk(16'h0500, i), i == 1);
        for (int i = 0; i < 4; i++)  add_exp(t0 + 22 + i, 1'b1, mk(16'h0400, 16 + i), 1'b0);
        tick(60);
        check_logs("t3");
        chk("t3_abort_count", 64'(abort_cyc.size()), 64'd1);
        if (abort_cyc.size() > 0) chk("t3_abort_cyc", 64'(abort_cyc[0]), 64'(t0 + 18));
        chk("t3_grant_held", 64'(s1_ready), 64'd1);

        // 3b: genuine last on the final allowed pixel is not an abort
        do_reset();
        clear_logs();
        t0 = cyc;
        push_line(0, 16, 16'h0600, 1'b1);
        for (int i = 0; i < 16; i++) add_exp(t0 + 2 + i, 1'b0, mk(16'h0600, i), i == 15);
        wait_idle("t3b", 100);
        check_logs("t3b");
        chk("t3b_abort_count", 64'(abort_cyc.size()), 64'd0);

        // 4: stream 0 valid gaps mid-line hold the grant against a waiting stream 1
        do_reset();
        clear_logs();
        t0 = cyc;
        push(0, mk(16'h0700, 0), 1'b0, 0);
        push(0, mk(16'h0700, 1), 1'b0, 0);
        push(0, mk(16'h0700, 2), 1'b0, 1);
        push(0, mk(16'h0700, 3), 1'b0, 0);
        push(0, mk(16'h0700, 4), 1'b0, 1);
        push(0, mk(16'h0700, 5), 1'b1, 0);
        push_line(1, 4, 16'h0800, 1'b1);
        add_exp(t0 + 2, 1'b0, mk(16'h0700, 0), 1'b0);
        add_exp(t0 + 3, 1'b0, mk(16'h0700, 1), 1'b0);
        add_exp(t0 + 5, 1'b0, mk(16'h0700, 2), 1'b0);
        add_exp(t0 + 6, 1'b0, mk(16'h0700, 3), 1'b0);
        add_exp(t0 + 8, 1'b0, mk(16'h0700, 4), 1'b0);
        add_exp(t0 + 9, 1'b0, mk(16'h0700, 5), 1'b1);
        for (int i = 0; i < 4; i++) add_exp(t0 + 11 + i, 1'b1, mk(16'h0800, i), i == 3);
        wait_idle("t4", 100);
        check_logs("t4");

        // 5: reset mid-line drops the partial line and restores stream 0 priority
        do_reset();
        clear_logs();
        push_line(0, 1, 16'h0900, 1'b1);
        wait_idle("t5_warm", 50);
        clear_logs();
        push_line(0, 6, 16'h0a00, 1'b1);
        n = 0;
        while (xl.size() < 3 && n < 50) begin tick(1); n++; end
        chk("t5_reach_px3", 64'(n < 50), 64'd1);
        rst = 1'b1;
        tick(1);
        chk("t5_s0_ready", 64'(s0_ready), 64'd0);
        chk("t5_s1_ready", 64'(s1_ready), 64'd0);
        chk("t5_csc_de", 64'(csc_de), 64'd0);
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(10);
        chk("t5_no_output", 64'(ol.size()), 64'd0);
        clear_logs();
        t0 = cyc;
        push_line(1, 1, 16'h0b00, 1'b1);
        push_line(0, 1, 16'h0c00, 1'b1);
        add_exp(t0 + 2, 1'b0, mk(16'h0c00, 0), 1'b1);
        add_exp(t0 + 4, 1'b1, mk(16'h0b00, 0), 1'b1);
        wait_idle("t5_rr", 50);
        check_logs("t5_rr");

        // 6: mid-scale grey through the converter model
        clear_logs();
        for (int i = 0; i < 3; i++) push(1, 48'h8000_8000_8000, i == 2, 0);
        wait_idle("t6", 50);
        chk("t6_out_count", 64'(ol.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < ol.size()) begin
                chk($sformatf("t6_rgb%0d", i), 64'(ol[i].rgb), 64'h0000_8000_8000_8000);
                chk($sformatf("t6_id%0d", i), 64'(ol[i].id), 64'd1);
                chk($sformatf("t6_last%0d", i), 64'(ol[i].last), 64'(i == 2));
            end
        end
        chk("rgb_zero_when_idle", 64'(leak), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
